// File: rtl/aud_pkg.sv
// Shared audio-peripheral definitions: PDM receiver FSM states and the sample
// width used by both the PDM capture path and the PWM output path.
package aud_pkg;

  localparam int unsigned AUD_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    RUN  = 2'd2
  } aud_pdm_state_t;

endpackage

// File: rtl/aud_sample_fifo.sv
// Synchronous sample FIFO, no fall-through.
//   clk, resetn : clock, asynchronous active-low reset
//   push        : write push_data (accepted when not full, or when full with a pop)
//   push_data   : sample to write
//   pop         : remove head entry (ignored when empty)
//   pop_data    : head entry, 0 while empty
//   full, empty : occupancy flags
//   level       : number of stored entries
module aud_sample_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? '0 : mem_q[rd_q];
  assign level    = cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/aud_pdm_rx.sv
// PDM microphone receiver: drives the mic bit clock, samples the 1-bit stream
// on each pdm_clk falling edge and counts ones over 2^DATA_WIDTH-1 bit windows.
// Completed windows are queued in a sample FIFO offered as a valid/ready stream.
//   clk, resetn  : system clock, asynchronous active-low reset
//   enable       : level, high runs capture
//   pdm_clk      : microphone clock, period 2*CLK_DIV clk cycles
//   pdm_lrsel    : channel select, tied low (left)
//   pdm_data     : microphone data, asynchronous to clk
//   sample_data  : FIFO head sample (unsigned count of ones)
//   sample_valid : FIFO not empty
//   sample_ready : consumer accepts head
//   overflow     : sticky, a completed sample was dropped on a full FIFO
//   level        : FIFO occupancy
module aud_pdm_rx
  import aud_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50,
  parameter int unsigned DATA_WIDTH   = AUD_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned SKIP_WINDOWS = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  output logic                          pdm_clk,
  output logic                          pdm_lrsel,
  input  logic                          pdm_data,
  output logic [DATA_WIDTH-1:0]         sample_data,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned SKIP_W = (SKIP_WINDOWS > 1) ? $clog2(SKIP_WINDOWS) : 1;

  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(CLK_DIV - 1);
  // Last bit index of a window: W-1 = 2^DATA_WIDTH - 2.
  localparam logic [DATA_WIDTH-1:0] BIT_LAST  = DATA_WIDTH'((1 << DATA_WIDTH) - 2);
  localparam logic [SKIP_W-1:0]     SKIP_LAST = SKIP_W'((SKIP_WINDOWS > 0) ? SKIP_WINDOWS - 1 : 0);

  logic                  sync1_q, sync2_q;
  aud_pdm_state_t        state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  pdm_clk_q, pdm_clk_d;
  logic [DATA_WIDTH-1:0] bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [SKIP_W-1:0]     skip_q, skip_d;
  logic                  push_q, push_d;
  logic [DATA_WIDTH-1:0] push_data_q, push_data_d;
  logic                  overflow_q, overflow_d;

  logic                  div_wrap;
  logic [DATA_WIDTH-1:0] window_sum;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign div_wrap   = (div_q == DIV_LAST);
  assign window_sum = acc_q + DATA_WIDTH'(sync2_q);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    pdm_clk_d   = pdm_clk_q;
    bitcnt_d    = bitcnt_q;
    acc_d       = acc_q;
    skip_d      = skip_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    overflow_d  = overflow_q;

    if (state_q == IDLE || !enable) begin
      // Idle, or leaving capture: clock parked low and any partial window dropped.
      div_d     = '0;
      pdm_clk_d = 1'b0;
      bitcnt_d  = '0;
      acc_d     = '0;
      skip_d    = '0;
      if (state_q == IDLE && enable) begin
        state_d    = (SKIP_WINDOWS == 0) ? RUN : SKIP;
        overflow_d = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end else begin
      div_d = div_wrap ? '0 : div_q + DIV_W'(1);
      if (div_wrap) pdm_clk_d = !pdm_clk_q;
      // Capture on the cycle that drives pdm_clk 1->0.
      if (div_wrap && pdm_clk_q) begin
        if (bitcnt_q == BIT_LAST) begin
          bitcnt_d = '0;
          acc_d    = '0;
          if (state_q == RUN) begin
            push_d      = 1'b1;
            push_data_d = window_sum;
          end else if (skip_q == SKIP_LAST) begin
            state_d = RUN;
            skip_d  = '0;
          end else begin
            skip_d = skip_q + SKIP_W'(1);
          end
        end else begin
          bitcnt_d = bitcnt_q + DATA_WIDTH'(1);
          acc_d    = window_sum;
        end
      end
    end

    if (push_q && fifo_full && !sample_ready) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= IDLE;
      div_q       <= '0;
      pdm_clk_q   <= 1'b0;
      bitcnt_q    <= '0;
      acc_q       <= '0;
      skip_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      sync1_q     <= pdm_data;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      div_q       <= div_d;
      pdm_clk_q   <= pdm_clk_d;
      bitcnt_q    <= bitcnt_d;
      acc_q       <= acc_d;
      skip_q      <= skip_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      overflow_q  <= overflow_d;
    end
  end

  aud_sample_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (sample_ready),
    .pop_data  (sample_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign pdm_clk      = pdm_clk_q;
  assign pdm_lrsel    = 1'b0;
  assign sample_valid = !fifo_empty;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_aud_pdm_rx.sv
// Directed bench for aud_pdm_rx with a reduced configuration
// (CLK_DIV=4, DATA_WIDTH=4 -> 15-bit windows of 120 clk cycles).
module tb_aud_pdm_rx;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DW      = 4;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned SKIP    = 2;

  logic          clk;
  logic          resetn;
  logic          enable;
  logic          pdm_data;
  logic          sample_ready;
  logic          pdm_clk;
  logic          pdm_lrsel;
  logic          sample_valid;
  logic          overflow;
  logic [DW-1:0] sample_data;
  logic [4:0]    level;

  int n_checks = 0;
  int n_errors = 0;
  int pat_mode = 0;   // 0 zeros, 1 ones, 2 alternating, 3 ramp (window w has w%16 ones)
  int k = 0;          // capture index since enable, owned by the mic process
  int n;

  aud_pdm_rx #(
    .CLK_DIV      (CLK_DIV),
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .SKIP_WINDOWS (SKIP)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .pdm_clk      (pdm_clk),
    .pdm_lrsel    (pdm_lrsel),
    .pdm_data     (pdm_data),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overflow     (overflow),
    .level        (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Microphone model: new bit on each pdm_clk rising edge, index restarts on disable.
  initial begin
    pdm_data = 1'b0;
    forever begin
      @(posedge pdm_clk or negedge enable);
      if (!enable) begin
        k = 0;
      end else begin
        case (pat_mode)
          1:       pdm_data = 1'b1;
          2:       pdm_data = ((k % 15) % 2 == 0);
          3:       pdm_data = ((k % 15) < ((k / 15) % 16));
          default: pdm_data = 1'b0;
        endcase
        k++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!sample_valid && cnt < 1000);
  endtask

  task automatic pop_check(input string tag, input int exp);
    int w = 0;
    while (!sample_valid && w < 400) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_vld"}, 32'(sample_valid), 1);
    check(tag, 32'(sample_data), exp);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
  endtask

  initial begin
    resetn       = 1'b0;
    enable       = 1'b0;
    sample_ready = 1'b0;
    tick(3);
    check("rst_pdm_clk", 32'(pdm_clk), 0);
    check("rst_lrsel",   32'(pdm_lrsel), 0);
    check("rst_data",    32'(sample_data), 0);
    check("rst_valid",   32'(sample_valid), 0);
    check("rst_ovf",     32'(overflow), 0);
    check("rst_level",   32'(level), 0);
    resetn = 1'b1;
    tick(2);

    // pdm_clk: first rise CLK_DIV cycles after enable is sampled, 4 high / 4 low.
    enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!pdm_clk && n < 50);
    check("pdmclk_first_rise", n, 5);
    n = 0;
    do begin @(negedge clk); n++; end while (pdm_clk && n < 50);
    check("pdmclk_high", n, 4);
    n = 0;
    do begin @(negedge clk); n++; end while (!pdm_clk && n < 50);
    check("pdmclk_low", n, 4);
    enable = 1'b0;
    tick(2);
    check("pdmclk_off", 32'(pdm_clk), 0);

    // All ones: 2 skipped windows, first push after 3*120 cycles, then full scale.
    pat_mode = 1;
    enable   = 1'b1;
    wait_valid(n);
    check("ones_first_lat", n, 362);
    pop_check("ones0", 15);
    pop_check("ones1", 15);
    enable = 1'b0;
    tick(3);
    check("ones_level", 32'(level), 0);

    pat_mode = 0;
    enable   = 1'b1;
    wait_valid(n);
    check("zeros_first_lat", n, 362);
    pop_check("zeros0", 0);
    pop_check("zeros1", 0);
    enable = 1'b0;
    tick(3);

    pat_mode = 2;
    enable   = 1'b1;
    wait_valid(n);
    check("alt_first_lat", n, 362);
    pop_check("alt0", 8);
    pop_check("alt1", 8);
    enable = 1'b0;
    tick(3);

    // Overflow: ready low, ramp data so run sample r carries (r+2)%16.
    pat_mode = 3;
    enable   = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!overflow && n < 3000);
    check("ovf_lat", n, 2282);
    check("ovf_level", 32'(level), 16);
    tick(130);
    check("ovf_level_18", 32'(level), 16);
    enable = 1'b0;
    tick(2);
    for (int i = 0; i < 16; i++) pop_check($sformatf("drain%0d", i), (i + 2) % 16);
    check("drain_valid", 32'(sample_valid), 0);
    check("drain_level", 32'(level), 0);
    check("drain_ovf_sticky", 32'(overflow), 1);

    // Re-enable clears overflow; then pop exactly in the 17th push cycle.
    enable = 1'b1;
    for (int c = 1; c <= 2290; c++) begin
      @(negedge clk);
      if (c == 1) check("ovf_cleared", 32'(overflow), 0);
      if (c == 2281) begin
        check("full_level_pre", 32'(level), 16);
        check("full_head_pre", 32'(sample_data), 2);
        sample_ready = 1'b1;
      end
      if (c == 2282) begin
        sample_ready = 1'b0;
        check("full_level_post", 32'(level), 16);
        check("full_ovf_post", 32'(overflow), 0);
        check("full_head_post", 32'(sample_data), 3);
      end
    end
    enable = 1'b0;
    tick(2);
    for (int i = 0; i < 16; i++) pop_check($sformatf("drain2_%0d", i), (i + 3) % 16);
    check("drain2_level", 32'(level), 0);

    // Disable halfway through the first run window.
    enable = 1'b1;
    tick(301);
    check("mid_pdmclk_hi", 32'(pdm_clk), 1);
    enable = 1'b0;
    tick(1);
    check("mid_pdmclk_lo", 32'(pdm_clk), 0);
    tick(200);
    check("mid_no_push", 32'(sample_valid), 0);
    check("mid_level", 32'(level), 0);
    enable = 1'b1;
    wait_valid(n);
    check("mid_reskip_lat", n, 362);
    pop_check("mid_first", 2);

    // Reset mid-window with 3 samples queued.
    n = 0;
    while (level != 3 && n < 1000) begin @(negedge clk); n++; end
    check("q3_level", 32'(level), 3);
    tick(60);
    resetn = 1'b0;
    enable = 1'b0;
    #1;
    check("arst_valid",   32'(sample_valid), 0);
    check("arst_level",   32'(level), 0);
    check("arst_data",    32'(sample_data), 0);
    check("arst_pdm_clk", 32'(pdm_clk), 0);
    check("arst_ovf",     32'(overflow), 0);
    tick(3);
    resetn = 1'b1;
    tick(100);
    check("post_rst_valid", 32'(sample_valid), 0);
    enable = 1'b1;
    wait_valid(n);
    check("post_rst_lat", n, 362);
    pop_check("post_rst_first", 2);
    check("lrsel_end", 32'(pdm_lrsel), 0);
    enable = 1'b0;
    tick(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
